// File: rtl/pipe_latch_chain_if.sv
// Handshake bundle for pipe_latch_chain: upstream valid/ready/data, downstream valid/ready/data, occupancy.
// Latency: none, wires only.
// Backpressure: carries in_ready/out_ready; the master drives in_* and out_ready, the slave drives the rest.
interface pipe_latch_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  // Producer/consumer side: presents input payload and downstream ready.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  // Chain side: accepts input, presents stage DEPTH-1 and occupancy.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );
endinterface

// File: rtl/pipe_latch_chain.sv
// Elastic DEPTH-stage valid-tagged register chain with sync flush, async clear and occupancy count.
// Latency: DEPTH active edges from acceptance to out_valid; 1 item/cycle throughput, bubbles collapse.
// Backpressure: in_ready = any empty stage or out_ready; full chain with out_ready=1 shifts without a bubble.
// Build option PIPE_NEGEDGE_EN: stage flops update on the falling clk edge instead of the rising edge.
module pipe_latch_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                flush,
  pipe_latch_chain_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [CNT_W-1:0] occ_cnt;

  // Ready chain: stage i can take data if out_ready or any stage at or after i is empty.
  // Formulated as a running AND from the output end so rdy has no self-referencing loop.
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    rdy       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v_q[i];
      rdy[i]    = bus.out_ready | ~tail_full;
    end
  end

  // Next stage state: shift where ready, hold where stalled; flush drops all valids, data held.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rdy[0]) begin
      v_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        d_d[0] = bus.in_data;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
        end
      end
    end
    if (flush) begin
      v_d = '0;
      d_d = d_q;
    end
  end

  // Stage registers; clr clears everything immediately regardless of clk.
`ifdef PIPE_NEGEDGE_EN
  always_ff @(negedge clk or negedge clr) begin
`else
  always_ff @(posedge clk or negedge clr) begin
`endif
    if (!clr) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  // Occupancy is a popcount of the registered valid bits only.
  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + CNT_W'(v_q[i]);
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.occupancy = occ_cnt;
endmodule
